d_jb_predict: RTL

- Parametrised next-generation jump/branch control for the decode stage of the MIPS pipeline.
- Decodes opcode/func into jump type, branch operation and link-write control, then registers the results into the D/E pipeline register.
- Adds a bimodal branch history table (BHT) of saturating counters for conditional-branch prediction.
- Takes execute-stage resolution to train the BHT and raise a registered pipeline flush on mispredict.

---
 rtl/jb_pkg.sv | 46 ++++
 rtl/jb_bht.sv | 42 ++++
 rtl/d_jb_predict.sv | 113 +++++++++++
 3 files changed

// File: rtl/jb_pkg.sv
// rtl/jb_pkg.sv - shared decode constants, enums and D/E register type for jump/branch control
package jb_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef enum logic [1:0] {
    JUMP_SEQ  = 2'b00,
    JUMP_DIR  = 2'b01,
    JUMP_REG  = 2'b10,
    JUMP_NONE = 2'b11
  } jump_e;

  typedef enum logic [2:0] {
    BOP_NONE = 3'b000,
    BOP_BNE  = 3'b010,
    BOP_BEQ  = 3'b011,
    BOP_BLEZ = 3'b100,
    BOP_BGTZ = 3'b101
  } bop_e;

  typedef struct packed {
    logic  valid;
    jump_e jump;
    bop_e  bop;
    logic  alu_pc4;
    logic  pred;
  } de_reg_t;

  localparam de_reg_t DE_BUBBLE = '{
    valid:   1'b0,
    jump:    JUMP_SEQ,
    bop:     BOP_NONE,
    alu_pc4: 1'b0,
    pred:    1'b0
  };

endpackage

// File: rtl/jb_bht.sv
// rtl/jb_bht.sv - bimodal table of saturating counters, combinational read, registered update
module jb_bht #(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_msb,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};

  logic [CTR_W-1:0] ctr [DEPTH];
  logic [CTR_W-1:0] wr_cur;

  assign wr_cur   = ctr[i_wr_idx];
  // Read uses the pre-edge array, so a same-cycle update is invisible to the lookup.
  assign o_rd_msb = ctr[i_rd_idx][CTR_W-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (i_wr_en) begin
      if (i_wr_taken && (wr_cur != CTR_MAX)) begin
        ctr[i_wr_idx] <= wr_cur + CTR_ONE;
      end else if (!i_wr_taken && (wr_cur != CTR_ZERO)) begin
        ctr[i_wr_idx] <= wr_cur - CTR_ONE;
      end
    end
  end

endmodule

// File: rtl/d_jb_predict.sv
// rtl/d_jb_predict.sv - decode-stage jump/branch control with BHT prediction; JB_STATS_EN adds counters
module d_jb_predict
  import jb_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dec_valid,
  input  logic [5:0]       i_dec_instru,
  input  logic [5:0]       i_dec_func,
  input  logic [IDX_W-1:0] i_dec_idx,
  input  logic             i_stall,
  input  logic             i_res_valid,
  input  logic [IDX_W-1:0] i_res_idx,
  input  logic             i_res_taken,
  input  logic             i_res_pred,
  output logic             o_valid,
  output logic [1:0]       o_con_jump,
  output logic [2:0]       o_con_bop,
  output logic             o_con_aluPC4,
  output logic             o_pred_taken,
  output logic             o_flush
`ifdef JB_STATS_EN
  ,
  output logic [STAT_W-1:0] o_stat_branches,
  output logic [STAT_W-1:0] o_stat_mispred
`endif
);

  de_reg_t de_q;
  de_reg_t dec;
  logic    is_cond;
  logic    is_uncond;
  logic    bht_msb;
  logic    mispred;

  jb_bht #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_bht (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_idx   (i_dec_idx),
    .o_rd_msb   (bht_msb),
    .i_wr_en    (i_res_valid),
    .i_wr_idx   (i_res_idx),
    .i_wr_taken (i_res_taken)
  );

  assign mispred = i_res_valid && (i_res_taken != i_res_pred);

  always_comb begin
    dec         = DE_BUBBLE;
    dec.valid   = 1'b1;
    dec.jump    = JUMP_NONE;
    is_cond     = 1'b0;
    is_uncond   = 1'b0;
    case (i_dec_instru)
      OP_BEQ:  begin dec.jump = JUMP_SEQ; dec.bop = BOP_BEQ;  is_cond = 1'b1; end
      OP_BNE:  begin dec.jump = JUMP_SEQ; dec.bop = BOP_BNE;  is_cond = 1'b1; end
      OP_BLEZ: begin dec.jump = JUMP_SEQ; dec.bop = BOP_BLEZ; is_cond = 1'b1; end
      OP_BGTZ: begin dec.jump = JUMP_SEQ; dec.bop = BOP_BGTZ; is_cond = 1'b1; end
      OP_J:    begin dec.jump = JUMP_DIR; is_uncond = 1'b1; end
      OP_JAL:  begin dec.jump = JUMP_DIR; dec.alu_pc4 = 1'b1; is_uncond = 1'b1; end
      OP_RTYPE: begin
        case (i_dec_func)
          FN_JR:   begin dec.jump = JUMP_REG; is_uncond = 1'b1; end
          FN_JALR: begin dec.jump = JUMP_REG; dec.alu_pc4 = 1'b1; is_uncond = 1'b1; end
          default: dec.jump = JUMP_SEQ;
        endcase
      end
      default: dec.jump = JUMP_NONE;
    endcase
    dec.pred = is_uncond | (is_cond & bht_msb);
  end

  // A mispredict squashes whatever would have entered D/E, even while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_q    <= DE_BUBBLE;
      o_flush <= 1'b0;
    end else begin
      o_flush <= mispred;
      if (mispred) begin
        de_q <= DE_BUBBLE;
      end else if (!i_stall) begin
        de_q <= i_dec_valid ? dec : DE_BUBBLE;
      end
    end
  end

  assign o_valid      = de_q.valid;
  assign o_con_jump   = de_q.jump;
  assign o_con_bop    = de_q.bop;
  assign o_con_aluPC4 = de_q.alu_pc4;
  assign o_pred_taken = de_q.pred;

`ifdef JB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_branches <= '0;
      o_stat_mispred  <= '0;
    end else begin
      if (i_res_valid) o_stat_branches <= o_stat_branches + 1'b1;
      if (mispred)     o_stat_mispred  <= o_stat_mispred + 1'b1;
    end
  end
`endif

endmodule
